// File: rtl/wb_pkg.sv
// Shared definitions for the write-back writer: register/data widths and
// the write-request record used by both the pipeline and multiply/divide paths.
package wb_pkg;

    localparam int REG_AW = 5;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [REG_AW-1:0] wa;
        logic [DATA_W-1:0] wd;
        logic [DATA_W-1:0] pc;
    } wb_req_t;

    function automatic wb_req_t wb_req(input logic [REG_AW-1:0] wa,
                                       input logic [DATA_W-1:0] wd,
                                       input logic [DATA_W-1:0] pc);
        wb_req_t r;
        r.wa = wa;
        r.wd = wd;
        r.pc = pc;
        return r;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Multiply/divide result buffer: power-of-two FIFO exposing every slot and its
// valid bit so the writer can flag pending destinations to the hazard unit.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  wb_req_t                din_i,
    output wb_req_t                head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output wb_req_t [DEPTH-1:0]    ent_o,
    output logic    [DEPTH-1:0]    ent_valid_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    wb_req_t [DEPTH-1:0] mem_q;
    logic    [DEPTH-1:0] valid_q;
    logic    [PW-1:0]    wr_ptr_q;
    logic    [PW-1:0]    rd_ptr_q;
    logic    [CW-1:0]    count_q;
    logic                do_push;
    logic                do_pop;

    assign full_o      = (count_q == CW'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign do_push     = push_i && !full_o;
    assign do_pop      = pop_i && !empty_o;
    assign head_o      = mem_q[rd_ptr_q];
    assign ent_o       = mem_q;
    assign ent_valid_o = valid_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '0;
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q]   <= din_i;
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q          <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= rd_ptr_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/wb_writer.sv
// Register-file write arbiter: pipeline writes always win, buffered mul/div
// results drain in idle slots. Define WB_TRACE_EN to print each committed write.
module wb_writer
    import wb_pkg::*;
#(
    parameter int MD_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p_valid,
    input  logic              p_we,
    input  logic [REG_AW-1:0] p_wa,
    input  logic [DATA_W-1:0] p_wd,
    input  logic [DATA_W-1:0] p_pc,
    input  logic              m_valid,
    output logic              m_ready,
    input  logic [REG_AW-1:0] m_wa,
    input  logic [DATA_W-1:0] m_wd,
    input  logic [DATA_W-1:0] m_pc,
    output logic              RegWrite,
    output logic [REG_AW-1:0] WA,
    output logic [DATA_W-1:0] WD,
    output logic [DATA_W-1:0] WPC,
    input  logic [REG_AW-1:0] ra1,
    input  logic [REG_AW-1:0] ra2,
    output logic              pend1,
    output logic              pend2,
    output logic              md_busy
);

    logic                   p_elig;
    logic                   md_push;
    logic                   md_pop;
    wb_req_t                md_head;
    logic                   md_full;
    logic                   md_empty;
    wb_req_t [MD_DEPTH-1:0] md_ent;
    logic    [MD_DEPTH-1:0] md_ent_valid;

    logic                   we_d, we_q;
    wb_req_t                req_d, req_q;

    assign p_elig  = p_valid && p_we && (p_wa != '0);
    // m_ready depends only on the registered count; the fifo gates push on full too.
    assign m_ready = !md_full;
    assign md_push = m_valid && m_ready && (m_wa != '0);
    assign md_pop  = !p_elig && !md_empty;
    assign md_busy = !md_empty;

    wb_fifo #(
        .DEPTH(MD_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (md_push),
        .pop_i      (md_pop),
        .din_i      (wb_req(m_wa, m_wd, m_pc)),
        .head_o     (md_head),
        .full_o     (md_full),
        .empty_o    (md_empty),
        .ent_o      (md_ent),
        .ent_valid_o(md_ent_valid)
    );

    always_comb begin
        we_d  = 1'b0;
        req_d = '0;
        if (p_elig) begin
            we_d  = 1'b1;
            req_d = wb_req(p_wa, p_wd, p_pc);
        end else if (!md_empty) begin
            we_d  = 1'b1;
            req_d = md_head;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q  <= 1'b0;
            req_q <= '0;
        end else begin
            we_q  <= we_d;
            req_q <= req_d;
        end
    end

    assign RegWrite = we_q;
    assign WA       = req_q.wa;
    assign WD       = req_q.wd;
    assign WPC      = req_q.pc;

    always_comb begin
        pend1 = 1'b0;
        pend2 = 1'b0;
        for (int i = 0; i < MD_DEPTH; i++) begin
            if (md_ent_valid[i] && (ra1 != '0) && (md_ent[i].wa == ra1)) pend1 = 1'b1;
            if (md_ent_valid[i] && (ra2 != '0) && (md_ent[i].wa == ra2)) pend2 = 1'b1;
        end
    end

`ifdef WB_TRACE_EN
    always @(posedge clk) begin
        if (!reset && RegWrite)
            $display("%0t@%08h: $%0d <= %08h", $time, WPC, WA, WD);
    end
`else
`endif

endmodule

// File: tb/tb_wb_writer.sv
// Directed bench for wb_writer (MD_DEPTH=2): hand-computed expectations for
// priority, discard, starvation, full/wrap behaviour and asynchronous reset.
module tb_wb_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        p_valid, p_we;
  logic [4:0]  p_wa;
  logic [31:0] p_wd, p_pc;
  logic        m_valid, m_ready;
  logic [4:0]  m_wa;
  logic [31:0] m_wd, m_pc;
  logic        RegWrite;
  logic [4:0]  WA;
  logic [31:0] WD, WPC;
  logic [4:0]  ra1, ra2;
  logic        pend1, pend2, md_busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_writer #(.MD_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .p_valid(p_valid), .p_we(p_we), .p_wa(p_wa), .p_wd(p_wd), .p_pc(p_pc),
    .m_valid(m_valid), .m_ready(m_ready), .m_wa(m_wa), .m_wd(m_wd), .m_pc(m_pc),
    .RegWrite(RegWrite), .WA(WA), .WD(WD), .WPC(WPC),
    .ra1(ra1), .ra2(ra2), .pend1(pend1), .pend2(pend2), .md_busy(md_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_p(input logic v, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [31:0] pc);
    p_valid = v; p_we = we; p_wa = wa; p_wd = wd; p_pc = pc;
  endtask

  task automatic drive_m(input logic v, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [31:0] pc);
    m_valid = v; m_wa = wa; m_wd = wd; m_pc = pc;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_we"}, {31'd0, RegWrite}, 32'd0);
    check({tag, "_wa"}, {27'd0, WA}, 32'd0);
    check({tag, "_wd"}, WD, 32'd0);
    check({tag, "_wpc"}, WPC, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    drive_p(0, 0, 0, 0, 0);
    drive_m(0, 0, 0, 0);
    ra1 = 0; ra2 = 0;
    #1;
    check_idle("rst");
    check("rst_mready", {31'd0, m_ready}, 32'd1);
    check("rst_busy", {31'd0, md_busy}, 32'd0);
    tick(); tick();
    #2 reset = 1'b0;
    tick();
    check_idle("post_rst");

    // Plain pipeline write, then idle.
    drive_p(1, 1, 5'd8, 32'h1234, 32'h100);
    tick();
    check("p_we", {31'd0, RegWrite}, 32'd1);
    check("p_wa", {27'd0, WA}, 32'd8);
    check("p_wd", WD, 32'h1234);
    check("p_wpc", WPC, 32'h100);
    drive_p(0, 0, 0, 0, 0);
    tick();
    check_idle("p_idle");

    // Writes to $0 and p_we=0 are dropped; md result to $0 is discarded.
    drive_p(1, 1, 5'd0, 32'hdead, 32'h104);
    drive_m(1, 5'd0, 32'hbeef, 32'h200);
    tick();
    check("z_we", {31'd0, RegWrite}, 32'd0);
    check("z_busy", {31'd0, md_busy}, 32'd0);
    check("z_mready", {31'd0, m_ready}, 32'd1);
    drive_p(1, 0, 5'd7, 32'hdead, 32'h108);
    drive_m(0, 0, 0, 0);
    tick();
    check("z_we2", {31'd0, RegWrite}, 32'd0);
    drive_p(0, 0, 0, 0, 0);
    tick();
    check("z_we3", {31'd0, RegWrite}, 32'd0);
    check("z_busy3", {31'd0, md_busy}, 32'd0);

    // Starvation: $3 buffered while pipeline writes $5 for four cycles.
    ra1 = 5'd3; ra2 = 5'd4;
    for (int i = 0; i < 4; i++) begin
      drive_p(1, 1, 5'd5, 32'h5000 + i, 32'h300 + 4 * i);
      drive_m(i == 0, 5'd3, 32'haaaa, 32'h400);
      tick();
      drive_m(0, 0, 0, 0);
      check($sformatf("st_wa%0d", i), {27'd0, WA}, 32'd5);
      check($sformatf("st_wd%0d", i), WD, 32'h5000 + i);
      check($sformatf("st_pend1_%0d", i), {31'd0, pend1}, 32'd1);
      check($sformatf("st_busy%0d", i), {31'd0, md_busy}, 32'd1);
    end
    check("st_pend2", {31'd0, pend2}, 32'd0);
    drive_p(0, 0, 0, 0, 0);
    tick();
    check("st_md_we", {31'd0, RegWrite}, 32'd1);
    check("st_md_wa", {27'd0, WA}, 32'd3);
    check("st_md_wd", WD, 32'haaaa);
    check("st_md_wpc", WPC, 32'h400);
    check("st_pend1_done", {31'd0, pend1}, 32'd0);
    check("st_busy_done", {31'd0, md_busy}, 32'd0);
    ra1 = 0; ra2 = 0;
    tick();
    check_idle("st_idle");

    // Fill (pipeline holds the port), block third offer, then drain across wrap.
    drive_p(1, 1, 5'd20, 32'h2020, 32'h500);
    drive_m(1, 5'd10, 32'ha0, 32'h600);
    tick();
    check("f_mready1", {31'd0, m_ready}, 32'd1);
    drive_m(1, 5'd11, 32'hb0, 32'h604);
    tick();
    check("f_mready2", {31'd0, m_ready}, 32'd0);
    check("f_wa2", {27'd0, WA}, 32'd20);
    drive_m(1, 5'd12, 32'hc0, 32'h608);
    tick();
    check("f_mready3", {31'd0, m_ready}, 32'd0);
    ra2 = 5'd11;
    #0;
    check("f_pend2", {31'd0, pend2}, 32'd1);
    drive_p(0, 0, 0, 0, 0);
    tick();
    check("f_pop_wa", {27'd0, WA}, 32'd10);
    check("f_pop_wd", WD, 32'ha0);
    check("f_nopush_mready", {31'd0, m_ready}, 32'd1);
    check("f_nopush_busy", {31'd0, md_busy}, 32'd1);
    tick();
    drive_m(0, 0, 0, 0);
    check("f_wa_b", {27'd0, WA}, 32'd11);
    check("f_wd_b", WD, 32'hb0);
    check("f_busy_c", {31'd0, md_busy}, 32'd1);
    check("f_pend2_gone", {31'd0, pend2}, 32'd0);
    tick();
    check("f_wa_c", {27'd0, WA}, 32'd12);
    check("f_wpc_c", WPC, 32'h608);
    check("f_busy_end", {31'd0, md_busy}, 32'd0);
    ra2 = 0;
    tick();
    check_idle("f_idle");

    // Asynchronous reset with two buffered entries and a write in flight.
    drive_p(1, 1, 5'd20, 32'h3030, 32'h700);
    drive_m(1, 5'd7, 32'h70, 32'h800);
    tick();
    drive_m(1, 5'd9, 32'h90, 32'h804);
    tick();
    drive_m(0, 0, 0, 0);
    check("r_full", {31'd0, m_ready}, 32'd0);
    check("r_inflight", {31'd0, RegWrite}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check_idle("r_async");
    check("r_mready", {31'd0, m_ready}, 32'd1);
    check("r_busy", {31'd0, md_busy}, 32'd0);
    drive_p(0, 0, 0, 0, 0);
    tick();
    #2 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("r_stale%0d", i), {31'd0, RegWrite}, 32'd0);
    end
    check("r_busy_end", {31'd0, md_busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
